// File: rtl/frame_buffer_db.sv
// -----------------------------------------------------------------------------
// frame_buffer_db
//
// Double-buffered frame store. A writer fills the back bank while a reader
// scans the front bank. The writer signals a finished frame with frame_done.
// The banks swap at the reader's next frame_start, so the reader never sees a
// half-written frame.
//
// Configuration macro:
//   FRAME_BUFFER_DOUBLE_BANK_EN
//     Defined:   two banks plus the IDLE/PENDING swap FSM.
//     Undefined: one bank shared by reader and writer.
//                front_bank, swap_pending and overrun are tied to 0.
//                frame_count counts frame_done pulses; frame_start is ignored.
//
// Ports:
//   CLOCK_50         in   single clock, all logic on the rising edge
//   reset_n          in   asynchronous active-low reset
//   write_enable     in   write strobe
//   data_in          in   pixel to write (PIX_W bits)
//   data_in_x/_y     in   write coordinates (COORD_W bits)
//   frame_done       in   one-cycle pulse: back frame complete
//   read_enable      in   read strobe
//   data_out_x/_y    in   read coordinates (COORD_W bits)
//   frame_start      in   one-cycle pulse: reader vsync
//   data_out         out  registered read pixel, held between reads
//   data_out_valid   out  high exactly one cycle after each read_enable
//   front_bank       out  bank currently served to the reader
//   swap_pending     out  swap requested, waiting for frame_start
//   overrun          out  sticky: frame_done arrived while a swap was pending
//   frame_count      out  completed swaps (frame_done pulses in single-bank)
// -----------------------------------------------------------------------------
module frame_buffer_db #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned COORD_W = 11
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               write_enable,
  input  logic [PIX_W-1:0]   data_in,
  input  logic [COORD_W-1:0] data_in_x,
  input  logic [COORD_W-1:0] data_in_y,
  input  logic               frame_done,
  input  logic               read_enable,
  input  logic [COORD_W-1:0] data_out_x,
  input  logic [COORD_W-1:0] data_out_y,
  input  logic               frame_start,
  output logic [PIX_W-1:0]   data_out,
  output logic               data_out_valid,
  output logic               front_bank,
  output logic               swap_pending,
  output logic               overrun,
  output logic [7:0]         frame_count
);

`ifdef FRAME_BUFFER_DOUBLE_BANK_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif

  localparam int unsigned Words  = H_RES * V_RES;
  localparam int unsigned MemAW  = $clog2(NumBanks * Words);

  // ---------------------------------------------------------------------------
  // Bank selection
  // ---------------------------------------------------------------------------
  logic front_q;
  logic rd_bank;
  logic wr_bank;

`ifdef FRAME_BUFFER_DOUBLE_BANK_EN
  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e     state_q, state_d;
  logic       front_d;
  logic       overrun_q, overrun_d;
  logic [7:0] count_q, count_d;

  // A swap takes effect on the clock edge. A read in the swap cycle therefore
  // still sees the pre-swap front bank.
  assign rd_bank = front_q;
  assign wr_bank = ~front_q;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        // A frame_start in the same cycle is consumed without swapping.
        if (frame_done) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (frame_start) begin
          front_d = ~front_q;
          count_d = count_q + 8'd1;
          state_d = frame_done ? StPending : StIdle;
        end
        // The writer finished another frame before the reader took the last one.
        if (frame_done) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      front_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign front_bank   = front_q;
  assign swap_pending = (state_q == StPending);
  assign overrun      = overrun_q;
  assign frame_count  = count_q;
`else
  logic [7:0] count_q;
  logic       unused_frame_start;

  assign unused_frame_start = frame_start;
  assign front_q            = 1'b0;
  assign rd_bank            = 1'b0;
  assign wr_bank            = 1'b0;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else if (frame_done) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign front_bank   = front_q;
  assign swap_pending = 1'b0;
  assign overrun      = 1'b0;
  assign frame_count  = count_q;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Coordinates are widened to 32 bits so range checks and the linear address
  // cannot wrap for any legal COORD_W.
  logic [31:0]      wr_x, wr_y, rd_x, rd_y;
  logic             wr_in_range, rd_in_range;
  logic [31:0]      wr_lin, rd_lin;
  logic [MemAW-1:0] wr_addr, rd_addr;

  assign wr_x = 32'(data_in_x);
  assign wr_y = 32'(data_in_y);
  assign rd_x = 32'(data_out_x);
  assign rd_y = 32'(data_out_y);

  assign wr_in_range = (wr_x < H_RES) && (wr_y < V_RES);
  assign rd_in_range = (rd_x < H_RES) && (rd_y < V_RES);

  always_comb begin
    wr_lin  = 32'd0;
    rd_lin  = 32'd0;
    wr_addr = '0;
    rd_addr = '0;
    if (wr_in_range) begin
      wr_lin  = wr_y * H_RES + wr_x + 32'(wr_bank) * Words;
      wr_addr = MemAW'(wr_lin);
    end
    if (rd_in_range) begin
      rd_lin  = rd_y * H_RES + rd_x + 32'(rd_bank) * Words;
      rd_addr = MemAW'(rd_lin);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: not reset, so the contents survive reset_n
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] mem_q [NumBanks * Words];

  always_ff @(posedge CLOCK_50) begin
    if (reset_n && write_enable && wr_in_range) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  // Reading mem_q here samples the pre-edge contents. A same-address write in
  // the same cycle therefore returns the old data.
  logic [PIX_W-1:0] dout_q;
  logic             dout_valid_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= read_enable;
      if (read_enable) begin
        dout_q <= rd_in_range ? mem_q[rd_addr] : '0;
      end
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dout_valid_q;

endmodule
